// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the 8-bit RISC CPU fetch path.
//   AW/DW/OPW  : address, data-bus and opcode widths (AW + OPW == 2*DW)
//   IR_W       : instruction register width (two bus bytes)
//   fetch_state_t : fetch FSM state encoding
package risc_pkg;

    localparam int AW   = 13;
    localparam int DW   = 8;
    localparam int OPW  = 3;
    localparam int IR_W = 2 * DW;

    // IR field positions: opcode in the top OPW bits, operand address below.
    localparam int IR_OP_MSB   = IR_W - 1;
    localparam int IR_OP_LSB   = AW;
    localparam int IR_ADDR_MSB = AW - 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_HI = 2'd1,
        ST_FETCH_LO = 2'd2,
        ST_VALID    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the controller handshake and program-memory bus
// signals of the fetch stage.
//   master : the fetch unit (drives mem_rd, addr_sel, pc_addr, ir_addr,
//            opcode, ir_valid; receives fetch_req, ir_ready, pc_load,
//            mem_data, mem_ack)
//   slave  : the environment (controller + memory), opposite directions
interface fetch_unit_if;
    import risc_pkg::*;

    logic           fetch_req;
    logic           ir_ready;
    logic           pc_load;
    logic [DW-1:0]  mem_data;
    logic           mem_ack;
    logic           mem_rd;
    logic           addr_sel;
    logic [AW-1:0]  pc_addr;
    logic [AW-1:0]  ir_addr;
    logic [OPW-1:0] opcode;
    logic           ir_valid;

    modport master (
        input  fetch_req, ir_ready, pc_load, mem_data, mem_ack,
        output mem_rd, addr_sel, pc_addr, ir_addr, opcode, ir_valid
    );

    modport slave (
        output fetch_req, ir_ready, pc_load, mem_data, mem_ack,
        input  mem_rd, addr_sel, pc_addr, ir_addr, opcode, ir_valid
    );

endinterface

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: W-bit program counter.
//   clk, rst_n  : clock, asynchronous active-low reset (clears to 0)
//   load_i      : synchronous load of load_val_i (wins over inc_i)
//   load_val_i  : value to load
//   inc_i       : increment by one, wrapping modulo 2^W
//   pc_o        : current counter value
module pc_counter
    import risc_pkg::*;
#(
    parameter int W = AW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            // Natural W-bit overflow provides the wrap to zero.
            pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Fetches a 16-bit instruction as two
// bytes (high byte first) over the 8-bit memory bus, holds it in the IR and
// offers it to the controller with a valid/ready handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if.master (controller handshake + memory bus)
module fetch_unit
    import risc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [IR_W-1:0] ir_q;
    logic            mem_rd_q;
    logic            addr_sel_q;
    logic            ir_valid_q;
    logic [AW-1:0]   pc;
    logic            ack_hi;
    logic            ack_lo;

    // A jump on the same edge as an ack discards the byte and the increment.
    assign ack_hi = (state_q == ST_FETCH_HI) && bus.mem_ack && !bus.pc_load;
    assign ack_lo = (state_q == ST_FETCH_LO) && bus.mem_ack && !bus.pc_load;

    always_comb begin
        state_d = state_q;
        if (bus.pc_load) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:     if (bus.fetch_req) state_d = ST_FETCH_HI;
                ST_FETCH_HI: if (bus.mem_ack)   state_d = ST_FETCH_LO;
                ST_FETCH_LO: if (bus.mem_ack)   state_d = ST_VALID;
                ST_VALID: begin
                    if (bus.ir_ready) begin
                        state_d = bus.fetch_req ? ST_FETCH_HI : ST_IDLE;
                    end
                end
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they align with state_q
    // and never see an input combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            mem_rd_q   <= 1'b0;
            addr_sel_q <= 1'b1;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_rd_q   <= (state_d == ST_FETCH_HI) || (state_d == ST_FETCH_LO);
            addr_sel_q <= (state_d == ST_IDLE) || (state_d == ST_VALID);
            ir_valid_q <= (state_d == ST_VALID);
            if (ack_hi) begin
                ir_q[IR_W-1:DW] <= bus.mem_data;
            end
            if (ack_lo) begin
                ir_q[DW-1:0] <= bus.mem_data;
            end
        end
    end

    pc_counter #(
        .W (AW)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (bus.pc_load),
        .load_val_i (ir_q[IR_ADDR_MSB:0]),
        .inc_i      (ack_hi || ack_lo),
        .pc_o       (pc)
    );

    assign bus.mem_rd   = mem_rd_q;
    assign bus.addr_sel = addr_sel_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.pc_addr  = pc;
    assign bus.ir_addr  = ir_q[IR_ADDR_MSB:0];
    assign bus.opcode   = ir_q[IR_OP_MSB:IR_OP_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A byte-array program
// memory answers reads at pc_addr with programmable wait states; expected
// instructions, PC values and latencies come from the memory contents and
// simple arithmetic on the PC.
module tb_fetch_unit;

    logic clk;
    logic rst_n;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [8192];
    int n_checks;
    int n_pass;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] model_ir(input logic [12:0] p);
        logic [12:0] p1;
        p1 = p + 13'd1;
        return {mem[p], mem[p1]};
    endfunction

    // Requests one instruction (from IDLE or VALID) and plays the memory,
    // inserting w_hi / w_lo wait cycles before each byte's ack.
    task automatic run_fetch(input int w_hi, input int w_lo, output int lat,
                             output bit rd_first, output bit valid_first,
                             output bit rd_cont, output int pc_changes,
                             output bit timeout);
        int waited;
        int cur_w;
        logic [12:0] last_pc;
        bus.fetch_req = 1'b1;
        bus.ir_ready  = 1'b1;
        bus.mem_ack   = 1'b0;
        step();
        bus.fetch_req = 1'b0;
        bus.ir_ready  = 1'b0;
        lat = 1;
        rd_first = bus.mem_rd;
        valid_first = bus.ir_valid;
        rd_cont = 1'b1;
        pc_changes = 0;
        timeout = 1'b0;
        waited = 0;
        cur_w = w_hi;
        last_pc = bus.pc_addr;
        while (!bus.ir_valid) begin
            if (lat > 60) begin
                timeout = 1'b1;
                break;
            end
            if (!bus.mem_rd) rd_cont = 1'b0;
            if (waited < cur_w) begin
                bus.mem_ack  = 1'b0;
                bus.mem_data = 8'($urandom);
                waited++;
            end else begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem[bus.pc_addr];
                waited = 0;
                cur_w = w_lo;
            end
            step();
            lat++;
            if (bus.pc_addr != last_pc) pc_changes++;
            last_pc = bus.pc_addr;
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fetch_req = 1'b0;
        bus.ir_ready  = 1'b0;
        bus.pc_load   = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_data  = 8'h00;
        #12;
        n_checks++; if (bus.pc_addr !== 13'd0) $display("FAIL rst_pc: got %h want 0", bus.pc_addr); else n_pass++;
        n_checks++; if (bus.mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b want 0", bus.mem_rd); else n_pass++;
        n_checks++; if (bus.addr_sel !== 1'b1) $display("FAIL rst_addr_sel: got %b want 1", bus.addr_sel); else n_pass++;
        n_checks++; if (bus.ir_valid !== 1'b0) $display("FAIL rst_ir_valid: got %b want 0", bus.ir_valid); else n_pass++;
        n_checks++; if ({bus.opcode, bus.ir_addr} !== 16'h0000) $display("FAIL rst_ir: got %h want 0000", {bus.opcode, bus.ir_addr}); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.addr_sel !== 1'b1) $display("FAIL rst_idle_hold: got rd=%b sel=%b want rd=0 sel=1", bus.mem_rd, bus.addr_sel); else n_pass++;
    endtask

    task automatic test_zero_wait();
        int lat, pcc; bit rf, vf, rc, to;
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;
        run_fetch(0, 0, lat, rf, vf, rc, pcc, to);
        $display("zero_wait: lat=%0d op=%b addr=%h pc=%h", lat, bus.opcode, bus.ir_addr, bus.pc_addr);
        n_checks++; if (to || lat !== 3) $display("FAIL zw_latency: got %0d (timeout=%0b) want 3", lat, to); else n_pass++;
        n_checks++; if (rf !== 1'b1) $display("FAIL zw_rd_after_req: got %b want 1", rf); else n_pass++;
        n_checks++; if (bus.opcode !== 3'b101) $display("FAIL zw_opcode: got %b want 101", bus.opcode); else n_pass++;
        n_checks++; if (bus.ir_addr !== 13'h053C) $display("FAIL zw_ir_addr: got %h want 053c", bus.ir_addr); else n_pass++;
        n_checks++; if (bus.pc_addr !== 13'd2) $display("FAIL zw_pc: got %h want 0002", bus.pc_addr); else n_pass++;
        n_checks++; if (bus.addr_sel !== 1'b1 || bus.mem_rd !== 1'b0) $display("FAIL zw_valid_outputs: got sel=%b rd=%b want sel=1 rd=0", bus.addr_sel, bus.mem_rd); else n_pass++;
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
        n_checks++; if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) $display("FAIL zw_accept_idle: got valid=%b rd=%b want 0/0", bus.ir_valid, bus.mem_rd); else n_pass++;
    endtask

    task automatic test_wait_states();
        int lat, pcc; bit rf, vf, rc, to;
        logic [15:0] exp_ir;
        exp_ir = model_ir(13'd2);
        run_fetch(2, 2, lat, rf, vf, rc, pcc, to);
        $display("wait_states: lat=%0d ir=%h pc=%h", lat, {bus.opcode, bus.ir_addr}, bus.pc_addr);
        n_checks++; if (to || lat !== 7) $display("FAIL ws_latency: got %0d (timeout=%0b) want 7", lat, to); else n_pass++;
        n_checks++; if (rc !== 1'b1) $display("FAIL ws_rd_continuous: got %b want 1", rc); else n_pass++;
        n_checks++; if (pcc !== 2) $display("FAIL ws_pc_steps: got %0d want 2", pcc); else n_pass++;
        n_checks++; if ({bus.opcode, bus.ir_addr} !== exp_ir) $display("FAIL ws_ir: got %h want %h", {bus.opcode, bus.ir_addr}, exp_ir); else n_pass++;
        n_checks++; if (bus.pc_addr !== 13'd4) $display("FAIL ws_pc: got %h want 0004", bus.pc_addr); else n_pass++;
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat, pcc; bit rf, vf, rc, to;
        logic [15:0] exp_ir;
        apply_reset();
        run_fetch(0, 0, lat, rf, vf, rc, pcc, to);
        exp_ir = model_ir(13'd0);
        n_checks++; if ({bus.opcode, bus.ir_addr} !== exp_ir) $display("FAIL b2b_first_ir: got %h want %h", {bus.opcode, bus.ir_addr}, exp_ir); else n_pass++;
        run_fetch(0, 0, lat, rf, vf, rc, pcc, to);
        exp_ir = model_ir(13'd2);
        $display("back_to_back: second ir=%h pc=%h lat=%0d", {bus.opcode, bus.ir_addr}, bus.pc_addr, lat);
        n_checks++; if (rf !== 1'b1 || vf !== 1'b0) $display("FAIL b2b_handover: got rd=%b valid=%b want rd=1 valid=0", rf, vf); else n_pass++;
        n_checks++; if (to || lat !== 3) $display("FAIL b2b_latency: got %0d want 3", lat); else n_pass++;
        n_checks++; if ({bus.opcode, bus.ir_addr} !== exp_ir) $display("FAIL b2b_second_ir: got %h want %h", {bus.opcode, bus.ir_addr}, exp_ir); else n_pass++;
        n_checks++; if (bus.pc_addr !== 13'd4) $display("FAIL b2b_pc: got %h want 0004", bus.pc_addr); else n_pass++;
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
    endtask

    task automatic test_jump();
        int lat, pcc; bit rf, vf, rc, to;
        logic [15:0] exp_ir;
        mem[4] = 8'hFF;
        mem[5] = 8'hFE;
        run_fetch(0, 0, lat, rf, vf, rc, pcc, to);
        n_checks++; if (bus.ir_addr !== 13'h1FFE) $display("FAIL jmp_target_ir: got %h want 1ffe", bus.ir_addr); else n_pass++;
        bus.pc_load = 1'b1;
        step();
        bus.pc_load = 1'b0;
        n_checks++; if (bus.pc_addr !== 13'h1FFE) $display("FAIL jmp_pc: got %h want 1ffe", bus.pc_addr); else n_pass++;
        n_checks++; if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.addr_sel !== 1'b1) $display("FAIL jmp_idle: got valid=%b rd=%b sel=%b want 0/0/1", bus.ir_valid, bus.mem_rd, bus.addr_sel); else n_pass++;
        exp_ir = {mem[13'h1FFE], mem[13'h1FFF]};
        run_fetch(1, 0, lat, rf, vf, rc, pcc, to);
        $display("jump: ir=%h pc=%h lat=%0d", {bus.opcode, bus.ir_addr}, bus.pc_addr, lat);
        n_checks++; if ({bus.opcode, bus.ir_addr} !== exp_ir) $display("FAIL jmp_wrap_ir: got %h want %h", {bus.opcode, bus.ir_addr}, exp_ir); else n_pass++;
        n_checks++; if (bus.pc_addr !== 13'd0) $display("FAIL jmp_wrap_pc: got %h want 0000", bus.pc_addr); else n_pass++;
        n_checks++; if (to || lat !== 4) $display("FAIL jmp_latency: got %0d want 4", lat); else n_pass++;
    endtask

    task automatic test_load_during_ack();
        logic [15:0] held;
        held = {mem[13'h1FFE], mem[13'h1FFF]};
        bus.fetch_req = 1'b1;
        bus.ir_ready  = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        bus.ir_ready  = 1'b0;
        n_checks++; if (bus.mem_rd !== 1'b1) $display("FAIL lda_in_fetch: got rd=%b want 1", bus.mem_rd); else n_pass++;
        bus.pc_load  = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_data = ~held[15:8];
        step();
        bus.pc_load = 1'b0;
        bus.mem_ack = 1'b0;
        $display("load_during_ack: pc=%h ir=%h rd=%b", bus.pc_addr, {bus.opcode, bus.ir_addr}, bus.mem_rd);
        n_checks++; if (bus.pc_addr !== held[12:0]) $display("FAIL lda_pc: got %h want %h", bus.pc_addr, held[12:0]); else n_pass++;
        n_checks++; if ({bus.opcode, bus.ir_addr} !== held) $display("FAIL lda_ir_untouched: got %h want %h", {bus.opcode, bus.ir_addr}, held); else n_pass++;
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.addr_sel !== 1'b1 || bus.ir_valid !== 1'b0) $display("FAIL lda_idle: got rd=%b sel=%b valid=%b want 0/1/0", bus.mem_rd, bus.addr_sel, bus.ir_valid); else n_pass++;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.pc_addr !== held[12:0]) $display("FAIL lda_idle_ignores_ack: got rd=%b pc=%h want 0/%h", bus.mem_rd, bus.pc_addr, held[12:0]); else n_pass++;
    endtask

    task automatic test_random();
        int lat, pcc; bit rf, vf, rc, to;
        int w_hi, w_lo, hold, action;
        logic [12:0] model_pc;
        logic [15:0] exp_ir;
        apply_reset();
        model_pc = 13'd0;
        for (int i = 0; i < 24; i++) begin
            w_hi = int'($urandom_range(0, 3));
            w_lo = int'($urandom_range(0, 3));
            exp_ir = model_ir(model_pc);
            model_pc = model_pc + 13'd2;
            run_fetch(w_hi, w_lo, lat, rf, vf, rc, pcc, to);
            $display("rand[%0d]: waits=%0d/%0d lat=%0d ir=%h pc=%h", i, w_hi, w_lo, lat, {bus.opcode, bus.ir_addr}, bus.pc_addr);
            n_checks++; if (to || lat !== 3 + w_hi + w_lo) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, 3 + w_hi + w_lo); else n_pass++;
            n_checks++; if ({bus.opcode, bus.ir_addr} !== exp_ir) $display("FAIL rnd_ir[%0d]: got %h want %h", i, {bus.opcode, bus.ir_addr}, exp_ir); else n_pass++;
            n_checks++; if (bus.pc_addr !== model_pc) $display("FAIL rnd_pc[%0d]: got %h want %h", i, bus.pc_addr, model_pc); else n_pass++;
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
                bus.mem_ack   = 1'($urandom);
                bus.mem_data  = 8'($urandom);
                bus.fetch_req = 1'($urandom);
                step();
            end
            bus.mem_ack   = 1'b0;
            bus.fetch_req = 1'b0;
            n_checks++; if (bus.ir_valid !== 1'b1 || {bus.opcode, bus.ir_addr} !== exp_ir || bus.pc_addr !== model_pc) $display("FAIL rnd_hold[%0d]: got valid=%b ir=%h pc=%h want 1/%h/%h", i, bus.ir_valid, {bus.opcode, bus.ir_addr}, bus.pc_addr, exp_ir, model_pc); else n_pass++;
            action = int'($urandom_range(0, 3));
            if (action == 0) begin
                bus.pc_load = 1'b1;
                step();
                bus.pc_load = 1'b0;
                model_pc = exp_ir[12:0];
                n_checks++; if (bus.pc_addr !== model_pc || bus.ir_valid !== 1'b0) $display("FAIL rnd_jump[%0d]: got pc=%h valid=%b want %h/0", i, bus.pc_addr, bus.ir_valid, model_pc); else n_pass++;
            end else if (action == 1) begin
                bus.ir_ready = 1'b1;
                step();
                bus.ir_ready = 1'b0;
                n_checks++; if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) $display("FAIL rnd_accept[%0d]: got valid=%b rd=%b want 0/0", i, bus.ir_valid, bus.mem_rd); else n_pass++;
                step();
            end
        end
    endtask

    task automatic test_reset_midfetch();
        int lat, pcc; bit rf, vf, rc, to;
        apply_reset();
        mem[0] = 8'h00;
        mem[1] = 8'h04;
        run_fetch(0, 0, lat, rf, vf, rc, pcc, to);
        bus.pc_load = 1'b1;
        step();
        bus.pc_load = 1'b0;
        bus.fetch_req = 1'b1;
        step();
        bus.fetch_req = 1'b0;
        bus.mem_ack  = 1'b1;
        bus.mem_data = 8'h77;
        step();
        bus.mem_ack = 1'b0;
        n_checks++; if (bus.pc_addr !== 13'd5 || bus.mem_rd !== 1'b1) $display("FAIL mid_setup: got pc=%h rd=%b want 0005/1", bus.pc_addr, bus.mem_rd); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_midfetch: pc=%h rd=%b sel=%b valid=%b", bus.pc_addr, bus.mem_rd, bus.addr_sel, bus.ir_valid);
        n_checks++; if (bus.pc_addr !== 13'd0) $display("FAIL mid_rst_pc: got %h want 0", bus.pc_addr); else n_pass++;
        n_checks++; if (bus.mem_rd !== 1'b0 || bus.addr_sel !== 1'b1 || bus.ir_valid !== 1'b0) $display("FAIL mid_rst_ctrl: got rd=%b sel=%b valid=%b want 0/1/0", bus.mem_rd, bus.addr_sel, bus.ir_valid); else n_pass++;
        n_checks++; if ({bus.opcode, bus.ir_addr} !== 16'h0000) $display("FAIL mid_rst_ir: got %h want 0000", {bus.opcode, bus.ir_addr}); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom);
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_back_to_back();
        test_jump();
        test_load_during_ack();
        test_random();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
